// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, width helpers and lane-index types for the register file
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 32;
  localparam int NWR_DEF    = 2;
  localparam int NRD_DEF    = 4;
  localparam int PEND_W_DEF = 2;

  // Address width for n registers; never narrower than one bit.
  function automatic int aw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold a per-cycle count of 0..n lanes.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  typedef logic [aw_of(NWR_DEF)-1:0] wr_lane_t;
  typedef logic [aw_of(NRD_DEF)-1:0] rd_port_t;

endpackage

// File: rtl/regfile_pend_ctr.sv
// rtl/regfile_pend_ctr.sv - per-register outstanding-write counter with saturating decrement
module regfile_pend_ctr
  import regfile_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF,
  parameter int CW     = cnt_w(NWR_DEF)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CW-1:0]     inc_i,
  input  logic [CW-1:0]     dec_i,
  input  logic              flush_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              unf_o
);

  localparam int EW = ((PEND_W > CW) ? PEND_W : CW) + 1;

  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0]     dec_eff, sum;

  // Writebacks beyond the outstanding count are clamped; the excess is the underflow.
  always_comb begin
    dec_eff = (EW'(dec_i) > EW'(cnt_q)) ? EW'(cnt_q) : EW'(dec_i);
    sum     = EW'(cnt_q) + EW'(inc_i) - dec_eff;
    cnt_d   = flush_i ? '0 : PEND_W'(sum);
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign unf_o = EW'(dec_i) > EW'(cnt_q);

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with wb bypass and pending-write scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NWR    = NWR_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NWR-1:0]          wb_en,
  input  logic [NWR*aw_of(NREG)-1:0] wb_addr,
  input  logic [NWR*DATA_W-1:0]   wb_data,
  input  logic [NWR-1:0]          iss_en,
  input  logic [NWR*aw_of(NREG)-1:0] iss_addr,
  output logic [NWR-1:0]          iss_full,
  input  logic                    flush,
  input  logic [NRD*aw_of(NREG)-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_ready,
  output logic                    err_ovf,
  output logic                    err_unf
);

  localparam int AW       = aw_of(NREG);
  localparam int CW       = cnt_w(NWR);
  localparam int EW       = ((PEND_W > CW) ? PEND_W : CW) + 1;
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [PEND_W-1:0] cnt    [NREG];
  logic [CW-1:0]     inc_n  [NREG];
  logic [CW-1:0]     dec_n  [NREG];
  logic [NREG-1:0]   unf;
  logic [NWR-1:0]    iss_full_raw, iss_acc, iss_ovf;
  logic              err_ovf_q, err_unf_q;

  // Prefix compare: older lanes to the same destination consume headroom first.
  always_comb begin
    for (int i = 0; i < NWR; i++) begin
      logic [AW-1:0] a;
      logic [EW-1:0] need;
      a    = iss_addr[i*AW +: AW];
      need = EW'(cnt[a]);
      for (int j = 0; j <= i; j++) begin
        if (iss_addr[j*AW +: AW] == a) need = need + EW'(1);
      end
      iss_full_raw[i] = (a != '0) && (need > EW'(PEND_MAX));
    end
  end

  assign iss_full = resetn ? iss_full_raw : '0;
  assign iss_acc  = iss_en & ~iss_full_raw & {NWR{~flush}};
  assign iss_ovf  = iss_en &  iss_full_raw & {NWR{~flush}};

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_n[r] = '0;
      dec_n[r] = '0;
      for (int i = 0; i < NWR; i++) begin
        if (iss_acc[i] && iss_addr[i*AW +: AW] == AW'(r)) inc_n[r] = inc_n[r] + CW'(1);
        if (wb_en[i]   && wb_addr[i*AW +: AW]  == AW'(r)) dec_n[r] = dec_n[r] + CW'(1);
      end
    end
  end

  assign cnt[0] = '0;
  assign unf[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_ctr
    regfile_pend_ctr #(
      .PEND_W (PEND_W),
      .CW     (CW)
    ) u_ctr (
      .clk     (clk),
      .resetn  (resetn),
      .inc_i   (inc_n[r]),
      .dec_i   (dec_n[r]),
      .flush_i (flush),
      .cnt_o   (cnt[r]),
      .unf_o   (unf[r])
    );
  end

  // Ascending lane order lets the youngest writer to an address win.
  always_comb begin
    for (int r = 0; r < NREG; r++) regs_d[r] = regs_q[r];
    for (int i = 0; i < NWR; i++) begin
      if (wb_en[i] && wb_addr[i*AW +: AW] != '0)
        regs_d[wb_addr[i*AW +: AW]] = wb_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0]     a;
      logic [DATA_W-1:0] d;
      a = rd_addr[k*AW +: AW];
      d = regs_q[a];
      for (int i = 0; i < NWR; i++) begin
        if (wb_en[i] && wb_addr[i*AW +: AW] == a) d = wb_data[i*DATA_W +: DATA_W];
      end
      if (!resetn || a == '0) d = '0;
      rd_data[k*DATA_W +: DATA_W] = d;
      rd_ready[k] = !resetn || (a == '0) || (EW'(dec_n[a]) >= EW'(cnt[a]));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_q | (|iss_ovf);
      err_unf_q <= err_unf_q | (|unf);
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  wb_en;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
  logic [1:0]  iss_en;
  logic [9:0]  iss_addr;
  logic [1:0]  iss_full;
  logic        flush;
  logic [19:0] rd_addr;
  logic [127:0] rd_data;
  logic [3:0]  rd_ready;
  logic        err_ovf;
  logic        err_unf;

  int n_pass  = 0;
  int n_total = 0;

  regfile_scoreboard dut (
    .clk      (clk),
    .resetn   (resetn),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_full (iss_full),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle();
    wb_en = '0; wb_addr = '0; wb_data = '0;
    iss_en = '0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wb(input int l, input logic [4:0] a, input logic [31:0] d);
    wb_en[l] = 1'b1;
    wb_addr[l*5 +: 5] = a;
    wb_data[l*32 +: 32] = d;
  endtask

  task automatic iss(input int l, input logic [4:0] a);
    iss_en[l] = 1'b1;
    iss_addr[l*5 +: 5] = a;
  endtask

  task automatic rd(input int k, input logic [4:0] a);
    rd_addr[k*5 +: 5] = a;
  endtask

  function automatic logic [31:0] rdd(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  initial begin
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;

    // populate r1/r2 and leave r1 pending before the reset pulse
    iss(0, 5'd1); iss(1, 5'd2);
    tick();
    wb(0, 5'd1, 32'hA1); wb(1, 5'd2, 32'hB2); iss(0, 5'd1);
    tick();
    rd(0, 5'd1); rd(1, 5'd2); #1;
    check("pre_rd_r1", rdd(0), 32'hA1);
    check("pre_rdy_r1", 32'(rd_ready[0]), 32'd0);
    check("pre_rd_r2", rdd(1), 32'hB2);

    resetn = 1'b0;
    wb(0, 5'd1, 32'hDEAD); iss(1, 5'd6); rd(0, 5'd1); rd(1, 5'd2); #1;
    check("rst_rd_nobypass", rdd(0), 32'd0);
    check("rst_rdy", 32'(rd_ready), 32'hF);
    check("rst_iss_full", 32'(iss_full), 32'd0);
    tick();
    resetn = 1'b1;
    rd(0, 5'd1); rd(1, 5'd2); #1;
    check("post_rst_r1", rdd(0), 32'd0);
    check("post_rst_r2", rdd(1), 32'd0);
    check("post_rst_rdy", 32'(rd_ready), 32'hF);
    check("post_rst_errs", {30'd0, err_ovf, err_unf}, 32'd0);

    // bypass priority: lane 1 is younger
    iss(0, 5'd5); iss(1, 5'd5);
    tick();
    wb(0, 5'd5, 32'h1111); wb(1, 5'd5, 32'h2222); rd(0, 5'd5); #1;
    check("byp_same_cycle", rdd(0), 32'h2222);
    check("byp_rdy", 32'(rd_ready[0]), 32'd1);
    tick();
    rd(0, 5'd5); #1;
    check("byp_array", rdd(0), 32'h2222);
    check("byp_no_unf", 32'(err_unf), 32'd0);

    // register 0
    wb(0, 5'd0, 32'hFFFF_FFFF); iss(1, 5'd0); rd(0, 5'd0); #1;
    check("r0_rd_byp", rdd(0), 32'd0);
    check("r0_rdy", 32'(rd_ready[0]), 32'd1);
    check("r0_full", 32'(iss_full), 32'd0);
    tick();
    rd(0, 5'd0); #1;
    check("r0_rd_array", rdd(0), 32'd0);
    check("r0_errs", {30'd0, err_ovf, err_unf}, 32'd0);

    // counter fill on r7
    iss(0, 5'd7); iss(1, 5'd7); rd(0, 5'd7); #1;
    check("r7_full_c0", 32'(iss_full), 32'd0);
    check("r7_rdy_c0", 32'(rd_ready[0]), 32'd1);
    tick();
    iss(0, 5'd7); #1;
    check("r7_full_c2", 32'(iss_full), 32'd0);
    tick();
    iss(0, 5'd7); rd(0, 5'd7); #1;
    check("r7_full_c3", 32'(iss_full), 32'd1);
    check("r7_rdy_c3", 32'(rd_ready[0]), 32'd0);
    tick();
    iss_addr[4:0] = 5'd7; rd(0, 5'd7); #1;
    check("r7_ovf", 32'(err_ovf), 32'd1);
    check("r7_full_kept", 32'(iss_full), 32'd1);
    wb(0, 5'd7, 32'h70); wb(1, 5'd7, 32'h71); #1;
    check("r7_rdy_2wb", 32'(rd_ready[0]), 32'd0);
    check("r7_rd_2wb", rdd(0), 32'h71);
    tick();
    wb(0, 5'd7, 32'h72); rd(0, 5'd7); #1;
    check("r7_rdy_3rd_wb", 32'(rd_ready[0]), 32'd1);
    check("r7_rd_3rd_wb", rdd(0), 32'h72);
    tick();
    rd(0, 5'd7); #1;
    check("r7_rdy_after", 32'(rd_ready[0]), 32'd1);
    check("r7_no_unf", 32'(err_unf), 32'd0);

    // issue and writeback to r9 in the same cycle
    iss(0, 5'd9);
    tick();
    iss(0, 5'd9); wb(1, 5'd9, 32'h99); rd(0, 5'd9); #1;
    check("r9_rd_byp", rdd(0), 32'h99);
    check("r9_rdy_same", 32'(rd_ready[0]), 32'd1);
    tick();
    rd(0, 5'd9); #1;
    check("r9_rdy_next", 32'(rd_ready[0]), 32'd0);
    wb(0, 5'd9, 32'h9A); #1;
    check("r9_rdy_drain", 32'(rd_ready[0]), 32'd1);
    tick();

    // flush with a concurrent issue
    iss(0, 5'd3); iss(1, 5'd3);
    tick();
    flush = 1'b1; iss(0, 5'd4); rd(0, 5'd3); rd(1, 5'd4); #1;
    check("fl_rdy_before", 32'(rd_ready[1:0]), 32'b10);
    tick();
    rd(0, 5'd3); rd(1, 5'd4); #1;
    check("fl_rdy_after", 32'(rd_ready[1:0]), 32'b11);
    check("fl_no_unf", 32'(err_unf), 32'd0);
    wb(0, 5'd3, 32'h33);
    tick();
    rd(0, 5'd3); #1;
    check("fl_unf", 32'(err_unf), 32'd1);
    check("fl_wb_landed", rdd(0), 32'h33);
    check("ovf_sticky", 32'(err_ovf), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
